register_file_mp: RTL

Parametrised successor to the CPU's 32x32 register bank. It has N independent registered read ports, one write port with optional write-to-read bypass, and an optional hardwired-zero register 0. A handshaked dump sequencer streams every register to the Debug Unit, one register per accepted beat. It sits in the ID stage: writes come from WB, and read data goes to the ID/EX latch.

---
 rtl/register_file_mp_pkg.sv | 12 +
 rtl/register_file_mp_dump_seq.sv | 72 +++++++
 rtl/register_file_mp.sv | 96 +++++++++
 3 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: dump sequencer state
// encodings and default datapath widths.
package rf_defs;
  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;
endpackage

// File: rtl/register_file_mp_dump_seq.sv
// Dump sequencer: walks a pointer over the bank and presents one register
// per handshaked beat to the Debug Unit.
module rf_dump_seq
  import rf_defs::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int NB_ADDR    = NB_ADDR_DEF,
  parameter int BANK_DEPTH = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_ADDR-1:0] o_ptr,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_busy,
  output logic               o_dump_done
);
  localparam logic [NB_ADDR-1:0] LAST_PTR = NB_ADDR'(BANK_DEPTH - 1);

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] ptr_q, ptr_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    o_dump_valid = 1'b0;
    o_dump_busy  = 1'b0;
    o_dump_done  = 1'b0;
    o_dump_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          ptr_d   = '0;
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        o_dump_valid = 1'b1;
        o_dump_busy  = 1'b1;
        o_dump_data  = i_reg_data;
        // The pointer parks on the last register; it never wraps.
        if (i_dump_ready) begin
          if (ptr_q == LAST_PTR) state_d = ST_DONE;
          else                   ptr_d   = ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        o_dump_done = 1'b1;
        o_dump_busy = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ptr       = ptr_q;
  assign o_dump_addr = ptr_q;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register bank for the ID stage: N registered read ports, one WB
// write port with optional bypass, optional hardwired r0, and a debug dump.
module register_file_mp
  import rf_defs::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int NB_ADDR      = NB_ADDR_DEF,
  parameter int BANK_DEPTH   = 32,
  parameter int N_READ       = 2,
  parameter int ZERO_REG     = 1,
  parameter int WRITE_BYPASS = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_reg_write,
  input  logic [NB_ADDR-1:0]        i_write_reg,
  input  logic [NB_DATA-1:0]        i_write_data,
  input  logic [N_READ*NB_ADDR-1:0] i_read_addr,
  output logic [N_READ*NB_DATA-1:0] o_read_data,
  input  logic                      i_dump_start,
  input  logic                      i_dump_ready,
  output logic                      o_dump_valid,
  output logic [NB_ADDR-1:0]        o_dump_addr,
  output logic [NB_DATA-1:0]        o_dump_data,
  output logic                      o_dump_busy,
  output logic                      o_dump_done
);
  localparam logic [NB_ADDR:0] DEPTH_EXT = (NB_ADDR + 1)'(BANK_DEPTH);

  logic [NB_DATA-1:0] regs_q [BANK_DEPTH];
  logic [NB_DATA-1:0] regs_d [BANK_DEPTH];
  logic [NB_DATA-1:0] rd_q   [N_READ];
  logic [NB_DATA-1:0] rd_d   [N_READ];
  logic [NB_ADDR-1:0] raddr  [N_READ];
  logic [NB_ADDR-1:0] dump_ptr;
  logic               wr_eff;

  // Addresses that always read as zero and can never be written.
  function automatic logic addr_is_null(input logic [NB_ADDR-1:0] a);
    return ({1'b0, a} >= DEPTH_EXT) || ((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_eff = i_enable && i_reg_write && !addr_is_null(i_write_reg);

  always_comb begin
    regs_d = regs_q;
    if (wr_eff) regs_d[i_write_reg] = i_write_data;
  end

  always_comb begin
    o_read_data = '0;
    for (int k = 0; k < N_READ; k++) begin
      raddr[k] = i_read_addr[k*NB_ADDR +: NB_ADDR];
      rd_d[k]  = rd_q[k];
      if (i_enable) begin
        if (addr_is_null(raddr[k]))
          rd_d[k] = '0;
        else if ((WRITE_BYPASS != 0) && wr_eff && (raddr[k] == i_write_reg))
          rd_d[k] = i_write_data;
        else
          rd_d[k] = regs_q[raddr[k]];
      end
      o_read_data[k*NB_DATA +: NB_DATA] = rd_q[k];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) regs_q[i] <= '0;
      for (int k = 0; k < N_READ; k++)     rd_q[k]   <= '0;
    end else begin
      regs_q <= regs_d;
      rd_q   <= rd_d;
    end
  end

  // Dump reads storage directly, so mid-dump WB writes show up unbypassed.
  rf_dump_seq #(
    .NB_DATA    (NB_DATA),
    .NB_ADDR    (NB_ADDR),
    .BANK_DEPTH (BANK_DEPTH)
  ) u_dump_seq (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .i_reg_data   (regs_q[dump_ptr]),
    .o_ptr        (dump_ptr),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );
endmodule
